// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and the core
// that fetches instructions and operands through it.
package mem_pkg;

    localparam int MEM_DW = 32;
    localparam int MEM_AW = 5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_t;

    // Instruction field positions, shared with the core decoder
    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;
    localparam int SRC1_HI = 25;
    localparam int SRC1_LO = 21;
    localparam int SRC2_HI = 20;
    localparam int SRC2_LO = 16;
    localparam int DEST_HI = 15;
    localparam int DEST_LO = 11;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;

    function automatic logic [5:0] op_of(input logic [MEM_DW-1:0] w);
        return w[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one combinational read
// port, all words cleared by the active-low asynchronous reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DW    = MEM_DW,
    parameter int AW    = MEM_AW,
    parameter int DEPTH = 2**AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Valid/ready memory slave with a programmable access latency; one
// request outstanding, one response per accepted request.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DW      = MEM_DW,
    parameter int AW      = MEM_AW,
    parameter int DEPTH   = 2**AW,
    parameter int LATENCY = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata
);

    mem_state_t    state;
    logic [3:0]    cnt;
    logic          held_we;
    logic [AW-1:0] held_addr;
    logic          accept;
    logic          mem_we;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign mem_we    = accept && req_we;

    // With LATENCY == 1 the response is captured on the accept edge,
    // before the holding register has the address.
    assign raddr = (state == IDLE) ? req_addr : held_addr;

    mem_array #(
        .DW   (DW),
        .AW   (AW),
        .DEPTH(DEPTH)
    ) u_array (
        .clock(clock),
        .reset(reset),
        .we   (mem_we),
        .waddr(req_addr),
        .wdata(req_wdata),
        .raddr(raddr),
        .rdata(rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            held_we   <= 1'b0;
            held_addr <= '0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        held_we   <= req_we;
                        held_addr <= req_addr;
                        cnt       <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_we    <= req_we;
                            rsp_rdata <= req_we ? '0 : rdata;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        cnt       <= '0;
                        rsp_we    <= held_we;
                        rsp_rdata <= held_we ? '0 : rdata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench: a LATENCY=2 and a LATENCY=1 responder
// share stimulus; sel picks which one is driven and observed.
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b1;

    logic        rr_a, rr_b, rv_a, rv_b, rw_a, rw_b;
    logic [31:0] rd_a, rd_b;
    logic        req_ready, rsp_valid, rsp_we;
    logic [31:0] rsp_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int n_rsp = 0;

    logic [31:0] model [2][32];
    logic [32:0] sb [$];

    always #5 clock = ~clock;

    assign req_ready = sel ? rr_b : rr_a;
    assign rsp_valid = sel ? rv_b : rv_a;
    assign rsp_we    = sel ? rw_b : rw_a;
    assign rsp_rdata = sel ? rd_b : rd_a;

    mem_responder #(.LATENCY(2)) u_dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid && !sel),
        .req_ready(rr_a),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rv_a),
        .rsp_ready(rsp_ready),
        .rsp_we   (rw_a),
        .rsp_rdata(rd_a)
    );

    mem_responder #(.LATENCY(1)) u_dut1 (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid && sel),
        .req_ready(rr_b),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rv_b),
        .rsp_ready(rsp_ready),
        .rsp_we   (rw_b),
        .rsp_rdata(rd_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [32:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            n_rsp++;
            chk({tag, "_we"}, 32'(rsp_we), 32'(e[32]));
            chk({tag, "_rdata"}, rsp_rdata, e[31:0]);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 32; i++)
                model[s][i] = '0;
    endtask

    // Called at a negedge with the selected DUT idle and rsp_ready=1
    task automatic xfer(input logic we, input logic [4:0] a,
                        input logic [31:0] d);
        int n;
        sb.push_back({we, we ? 32'h0 : model[sel][a]});
        if (we) model[sel][a] = d;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("latency", 32'(n), sel ? 32'd1 : 32'd2);
        pop_chk("rsp");
        chk("no_ready_in_resp", 32'(req_ready), 32'd0);
        @(negedge clock);
        chk("back_idle", {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        logic [32:0] e;
        int n;
        clear_model();
        repeat (2) @(negedge clock);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_we", 32'(rsp_we), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        xfer(1'b1, 5'd0, 32'h0420_0800);
        xfer(1'b1, 5'd7, 32'h0000_0003);
        xfer(1'b0, 5'd7, 32'h0);
        xfer(1'b1, 5'd5, 32'h0000_0055);

        // Backpressure: response held while a new request waits
        rsp_ready = 1'b0;
        sb.push_back({1'b0, model[0][7]});
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 5'd7;
        @(negedge clock);
        req_addr = 5'd5;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("bp_latency", 32'(n), 32'd2);
        e = sb.pop_front();
        n_rsp++;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, e[31:0]);
            chk("bp_we", 32'(rsp_we), 32'(e[32]));
            chk("bp_ready", 32'(req_ready), 32'd0);
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        sb.push_back({1'b0, model[0][5]});
        @(negedge clock);
        chk("bp_release", {30'd0, rsp_valid, req_ready}, 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        chk("bp_held_accept", 32'(req_ready), 32'd0);
        @(negedge clock);
        chk("bp_held_valid", 32'(rsp_valid), 32'd1);
        pop_chk("bp_held");
        @(negedge clock);

        sel = 1'b1;
        xfer(1'b1, 5'd2, 32'h0C62_2000);
        xfer(1'b0, 5'd2, 32'h0);
        sel = 1'b0;

        // Reset while a read is in BUSY
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 5'd7;
        @(negedge clock);
        req_valid = 1'b0;
        chk("busy_before_rst", 32'(rsp_valid), 32'd0);
        #2 reset = 1'b0;
        #1 chk("rst_async_valid", 32'(rsp_valid), 32'd0);
        @(negedge clock);
        chk("rst_dropped", 32'(rsp_valid), 32'd0);
        clear_model();
        reset = 1'b1;
        @(negedge clock);
        chk("rst_rel_ready", 32'(req_ready), 32'd1);
        xfer(1'b0, 5'd7, 32'h0);

        n_rsp = 0;
        for (int i = 0; i < 32; i++) xfer(1'b1, 5'(i), 32'(i * 3));
        for (int i = 0; i < 32; i++) xfer(1'b0, 5'(i), 32'h0);
        chk("rsp_count", 32'(n_rsp), 32'd64);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
